// File: rtl/speed_pulse_gen.sv
// Speed-command to step-pulse generator.
// Phase-continuous modulo accumulator, fixed-width pulses, free-run and burst.
module speed_pulse_gen #(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned WIN_DIV   = 10,
  parameter int unsigned PULSE_W   = 25,
  parameter logic [23:0] MAX_SPEED = 24'hFFFFFF
) (
  input  logic        clk_50m,
  input  logic        rst,
  input  logic        en,
  input  logic [23:0] speed_cmd,
  input  logic        cmd_load,
  input  logic        burst_start,
  input  logic [15:0] burst_len,
  output logic        pulse_out,
  output logic        busy,
  output logic        burst_done,
  output logic [23:0] pulse_count,
  output logic        sat
);

  localparam logic [63:0] MOD_L =
    (64'(CLK_HZ) / 64'(WIN_DIV)) * 64'd256;
  localparam logic [32:0] MOD = MOD_L[32:0];
  localparam int PW_W = $clog2(PULSE_W + 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] RUN_CONT  = 2'd1;
  localparam logic [1:0] RUN_BURST = 2'd2;
  localparam logic [1:0] DRAIN     = 2'd3;

  logic [1:0]      state;
  logic [23:0]     speed_reg;
  logic [31:0]     acc;
  logic [32:0]     sum;
  logic            run;
  logic            tick;
  logic [PW_W-1:0] pw_cnt;
  logic [15:0]     remaining;
  logic            from_burst;

  assign run  = (state == RUN_CONT) || (state == RUN_BURST);
  assign sum  = {1'b0, acc} + {9'd0, speed_reg};
  assign tick = run && (sum >= MOD);

  // High while the shaper counter is non-zero: rst clears it at once.
  assign pulse_out = (pw_cnt != '0);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state       <= IDLE;
      speed_reg   <= '0;
      sat         <= 1'b0;
      acc         <= '0;
      pw_cnt      <= '0;
      pulse_count <= '0;
      remaining   <= '0;
      from_burst  <= 1'b0;
      burst_done  <= 1'b0;
    end else begin
      burst_done <= 1'b0;

      if (cmd_load) begin
        speed_reg <= (speed_cmd > MAX_SPEED) ? MAX_SPEED : speed_cmd;
        sat       <= (speed_cmd > MAX_SPEED);
      end

      if (run) begin
        acc <= 32'(tick ? (sum - MOD) : sum);
      end

      if (tick) begin
        pw_cnt      <= PW_W'(PULSE_W);
        pulse_count <= pulse_count + 24'd1;
      end else if (pw_cnt != '0) begin
        pw_cnt <= pw_cnt - 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (burst_start) begin
            if (burst_len != '0) begin
              state       <= RUN_BURST;
              acc         <= '0;
              pulse_count <= '0;
              remaining   <= burst_len;
            end else begin
              burst_done <= 1'b1;
            end
          end else if (en) begin
            state       <= RUN_CONT;
            acc         <= '0;
            pulse_count <= '0;
          end
        end
        RUN_CONT: begin
          if (!en) begin
            state      <= DRAIN;
            from_burst <= 1'b0;
          end
        end
        RUN_BURST: begin
          if (tick) begin
            remaining <= remaining - 1'b1;
            if (remaining == 16'd1) begin
              state      <= DRAIN;
              from_burst <= 1'b1;
            end
          end
        end
        DRAIN: begin
          // Leave only once the last pulse has fully dropped.
          if (pw_cnt == '0) begin
            state      <= IDLE;
            burst_done <= from_burst;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
